// File: rtl/seq_divider_if.sv
// Handshake/data bundle between the control unit and the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [5:0]         Signal;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;
  logic               div_zero;

  // Control unit side: issues commands and operands, reads results.
  modport master (
    output dataA, dataB, Signal,
    input  dataOut, busy, done, div_zero
  );

  // Divider side.
  modport slave (
    input  dataA, dataB, Signal,
    output dataOut, busy, done, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed (DIV) or unsigned (DIVU), one quotient
// bit per cycle. The result is kept internally and copied to dataOut on OUT.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [5:0] CMD_DIV  = 6'd26;
  localparam logic [5:0] CMD_DIVU = 6'd27;
  localparam logic [5:0] CMD_OUT  = 6'd63;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   rem, quo, divisor, dividend_raw;
  logic               q_neg, r_neg, dz;
  logic [2*WIDTH-1:0] data_out;
  logic               busy, done;

  // Start decode and operand conditioning (magnitudes in signed mode).
  logic             start, is_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  assign start     = ((state == IDLE) || (state == DONE)) &&
                     ((bus.Signal == CMD_DIV) || (bus.Signal == CMD_DIVU));
  assign is_signed = (bus.Signal == CMD_DIV);
  assign a_neg     = is_signed & bus.dataA[WIDTH-1];
  assign b_neg     = is_signed & bus.dataB[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.dataA + 1'b1) : bus.dataA;
  assign b_mag     = b_neg ? (~bus.dataB + 1'b1) : bus.dataB;
  assign b_zero    = (bus.dataB == '0);

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  // rem < divisor always holds, so WIDTH+1 bits cannot overflow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a start in DONE discards the unread result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = b_zero ? FIX : RUN;
      RUN:  if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        if (start)                       state_next = b_zero ? FIX : RUN;
        else if (bus.Signal == CMD_OUT)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state, so busy and done are mutually exclusive.
  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  // Datapath: operand latch, iteration, sign fix-up and result hand-off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz           <= 1'b0;
      data_out     <= '0;
    end else if (start) begin
      count        <= b_zero ? '0 : CW'(WIDTH);
      rem          <= '0;
      quo          <= a_mag;
      divisor      <= b_mag;
      dividend_raw <= bus.dataA;
      q_neg        <= a_neg ^ b_neg;
      r_neg        <= a_neg;
      dz           <= b_zero;
    end else begin
      case (state)
        RUN: begin
          count <= count - 1'b1;
          rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end
        FIX: begin
          if (dz) begin
            quo <= '1;
            rem <= dividend_raw;
          end else begin
            if (q_neg) quo <= ~quo + 1'b1;
            if (r_neg) rem <= ~rem + 1'b1;
          end
        end
        DONE: if (bus.Signal == CMD_OUT) data_out <= {quo, rem};
        default: ;
      endcase
    end
  end

  assign bus.dataOut  = data_out;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = dz;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH 32, 16 and 8 with a result scoreboard.
module tb_seq_divider;
  localparam logic [5:0] CMD_NOP  = 6'd0;
  localparam logic [5:0] CMD_DIV  = 6'd26;
  localparam logic [5:0] CMD_DIVU = 6'd27;
  localparam logic [5:0] CMD_OUT  = 6'd63;
  localparam int N_RAND = 150;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int           w;
    logic [127:0] res;
    logic         dz;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(16)) bus16 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  // busy and done must never be high together on any instance.
  always @(negedge clk) begin
    checks++;
    if ((bus32.busy & bus32.done) | (bus16.busy & bus16.done) | (bus8.busy & bus8.done)) begin
      errors++;
      $display("FAIL busy_done_overlap got b32=%b%b b16=%b%b b8=%b%b want never both",
               bus32.busy, bus32.done, bus16.busy, bus16.done, bus8.busy, bus8.done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int w, logic [5:0] sig, logic [63:0] a, logic [63:0] b);
    case (w)
      32: begin bus32.Signal = sig; bus32.dataA = a[31:0]; bus32.dataB = b[31:0]; end
      16: begin bus16.Signal = sig; bus16.dataA = a[15:0]; bus16.dataB = b[15:0]; end
      default: begin bus8.Signal = sig; bus8.dataA = a[7:0]; bus8.dataB = b[7:0]; end
    endcase
  endtask

  function automatic logic [127:0] get_out(int w);
    case (w)
      32: return 128'(bus32.dataOut);
      16: return 128'(bus16.dataOut);
      default: return 128'(bus8.dataOut);
    endcase
  endfunction

  function automatic logic get_busy(int w);
    case (w)
      32: return bus32.busy;
      16: return bus16.busy;
      default: return bus8.busy;
    endcase
  endfunction

  function automatic logic get_done(int w);
    case (w)
      32: return bus32.done;
      16: return bus16.done;
      default: return bus8.done;
    endcase
  endfunction

  function automatic logic get_dz(int w);
    case (w)
      32: return bus32.div_zero;
      16: return bus16.div_zero;
      default: return bus8.div_zero;
    endcase
  endfunction

  // Reference: language / and % (truncation toward zero), plus the divide-by-zero rule.
  function automatic logic [127:0] model(int w, logic [5:0] sig, logic [63:0] a_in, logic [63:0] b_in);
    logic [63:0] mask, a, b, q, r;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 64'd0) begin
      q = mask;
      r = a;
    end else if (sig == CMD_DIVU) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'(a << (64 - w));
      sa = sa >>> (64 - w);
      sb = longint'(b << (64 - w));
      sb = sb >>> (64 - w);
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end
    return ((128'(q & mask)) << w) | 128'(r & mask);
  endfunction

  function automatic logic [127:0] pack(int w, logic [63:0] q, logic [63:0] r);
    return (128'(q) << w) | 128'(r);
  endfunction

  task automatic sb_push(int w, logic [127:0] res, logic dz);
    sb_entry_t e;
    e.w = w; e.res = res; e.dz = dz;
    sb_q.push_back(e);
  endtask

  // Issue a start; returns one cycle after edge 0.
  task automatic start_op(int w, logic [5:0] sig, logic [63:0] a, logic [63:0] b);
    drive(w, sig, a, b);
    tick();
    drive(w, CMD_NOP, a, b);
  endtask

  // Wait for done, with n0 edges already elapsed since start; checks total latency.
  task automatic wait_done(int w, int n0, int exp_edges, string tag);
    int n;
    n = n0;
    while (get_done(w) !== 1'b1 && n < w + 10) begin
      tick();
      n++;
    end
    checks++;
    if (get_done(w) !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got done=%b want 1 within %0d edges", tag, get_done(w), w + 10);
    end else if (n != exp_edges) begin
      errors++;
      $display("FAIL %s_latency got %0d edges want %0d", tag, n, exp_edges);
    end
  endtask

  task automatic read_out(int w, string tag);
    sb_entry_t e;
    logic [127:0] got;
    drive(w, CMD_OUT, 64'd0, 64'd0);
    tick();
    drive(w, CMD_NOP, 64'd0, 64'd0);
    got = get_out(w);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty queue want an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    if (got !== e.res) begin
      errors++;
      $display("FAIL %s_dataOut got %h want %h", tag, got, e.res);
    end
    checks++;
    if (get_dz(w) !== e.dz) begin
      errors++;
      $display("FAIL %s_div_zero got %b want %b", tag, get_dz(w), e.dz);
    end
    checks++;
    if (get_done(w) !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_after_out got %b want 0", tag, get_done(w));
    end
    $display("txn %s w=%0d dataOut=%h div_zero=%b", tag, w, got, get_dz(w));
  endtask

  task automatic run_op(int w, logic [5:0] sig, logic [63:0] a, logic [63:0] b,
                        logic [127:0] exp_res, logic exp_dz, string tag);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sb_push(w, exp_res, exp_dz);
    start_op(w, sig, a, b);
    checks++;
    if (get_busy(w) !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_after_start got %b want 1", tag, get_busy(w));
    end
    wait_done(w, 1, ((b & mask) == 64'd0) ? 2 : w + 2, tag);
    read_out(w, tag);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus32.dataOut, bus32.busy, bus32.done, bus32.div_zero,
         bus16.dataOut, bus16.busy, bus16.done, bus16.div_zero,
         bus8.dataOut, bus8.busy, bus8.done, bus8.div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got out32=%h b=%b d=%b z=%b want all 0",
               bus32.dataOut, bus32.busy, bus32.done, bus32.div_zero);
    end
    $display("txn reset outputs checked");
  endtask

  task automatic test_divu();
    run_op(32, CMD_DIVU, 64'd100, 64'd7, pack(32, 64'd14, 64'd2), 1'b0, "divu_100_7");
  endtask

  task automatic test_div_signed();
    run_op(32, CMD_DIV, 64'hFFFFFFF9, 64'd2, pack(32, 64'hFFFFFFFD, 64'hFFFFFFFF), 1'b0, "div_m7_2");
    run_op(32, CMD_DIV, 64'd7, 64'hFFFFFFFE, pack(32, 64'hFFFFFFFD, 64'h00000001), 1'b0, "div_7_m2");
    run_op(32, CMD_DIV, 64'h80000000, 64'hFFFFFFFF, pack(32, 64'h80000000, 64'h0), 1'b0, "div_min_m1");
  endtask

  task automatic test_div_zero();
    run_op(32, CMD_DIVU, 64'h1234, 64'd0, pack(32, 64'hFFFFFFFF, 64'h1234), 1'b1, "divu_by_zero");
    run_op(32, CMD_DIV, 64'hFFFFFF00, 64'd0, pack(32, 64'hFFFFFFFF, 64'hFFFFFF00), 1'b1, "div_by_zero");
    // Next accepted start clears the flag immediately.
    sb_push(32, pack(32, 64'd3, 64'd1), 1'b0);
    start_op(32, CMD_DIVU, 64'd10, 64'd3);
    checks++;
    if (bus32.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear_on_start got %b want 0", bus32.div_zero);
    end
    wait_done(32, 1, 34, "dz_clear");
    read_out(32, "dz_clear");
  endtask

  task automatic test_reset_abort();
    start_op(32, CMD_DIVU, 64'hFFFFFFFF, 64'd3);
    for (int i = 1; i < 10; i++) tick();
    @(posedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus32.dataOut, bus32.busy, bus32.done, bus32.div_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got out=%h b=%b d=%b z=%b want all 0",
               bus32.dataOut, bus32.busy, bus32.done, bus32.div_zero);
    end
    tick();
    reset = 1'b1;
    tick();
    drive(32, CMD_OUT, 64'd0, 64'd0);
    tick();
    drive(32, CMD_NOP, 64'd0, 64'd0);
    checks++;
    if (bus32.dataOut !== 64'd0 || bus32.done !== 1'b0) begin
      errors++;
      $display("FAIL out_in_idle got out=%h done=%b want 0 0", bus32.dataOut, bus32.done);
    end
    $display("txn reset_abort w=32 dataOut=%h", bus32.dataOut);
  endtask

  task automatic test_ignored();
    sb_push(32, pack(32, 64'd14, 64'd2), 1'b0);
    start_op(32, CMD_DIVU, 64'd100, 64'd7);
    for (int i = 0; i < 5; i++) tick();
    drive(32, CMD_DIVU, 64'd5, 64'd1);
    tick();
    drive(32, CMD_OUT, 64'd0, 64'd0);
    tick();
    drive(32, CMD_NOP, 64'd0, 64'd0);
    checks++;
    if (bus32.dataOut !== 64'd0 || bus32.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignored_in_run got out=%h busy=%b want 0 1", bus32.dataOut, bus32.busy);
    end
    wait_done(32, 8, 34, "ignored");
    read_out(32, "ignored");
  endtask

  task automatic test_width8_discard();
    run_op(8, CMD_DIVU, 64'd200, 64'd3, 128'h4202, 1'b0, "w8_200_3");
    // Reach DONE without reading, then restart from DONE: result is discarded.
    start_op(8, CMD_DIVU, 64'd50, 64'd5);
    wait_done(8, 1, 10, "w8_unread");
    checks++;
    if (bus8.dataOut !== 16'h4202) begin
      errors++;
      $display("FAIL w8_hold_in_done got %h want 4202", bus8.dataOut);
    end
    sb_push(8, 128'h0201, 1'b0);
    start_op(8, CMD_DIVU, 64'd9, 64'd4);
    checks++;
    if (bus8.dataOut !== 16'h4202 || bus8.busy !== 1'b1) begin
      errors++;
      $display("FAIL w8_restart_from_done got out=%h busy=%b want 4202 1", bus8.dataOut, bus8.busy);
    end
    wait_done(8, 1, 10, "w8_9_4");
    checks++;
    if (bus8.dataOut !== 16'h4202) begin
      errors++;
      $display("FAIL w8_hold_before_out got %h want 4202", bus8.dataOut);
    end
    read_out(8, "w8_9_4");
  endtask

  task automatic test_random();
    int widths[2] = '{32, 16};
    logic [5:0] modes[2] = '{CMD_DIV, CMD_DIVU};
    logic [63:0] a, b, mask;
    int w;
    for (int wi = 0; wi < 2; wi++) begin
      w = widths[wi];
      mask = (64'd1 << w) - 64'd1;
      for (int mi = 0; mi < 2; mi++) begin
        for (int k = 0; k < N_RAND; k++) begin
          a = 64'($urandom()) & mask;
          b = (64'($urandom()) >> $urandom_range(0, w - 1)) & mask;
          case ($urandom_range(0, 15))
            0: b = 64'd0;
            1: begin a = 64'd1 << (w - 1); b = mask; end
            2: b = 64'd1;
            default: ;
          endcase
          run_op(w, modes[mi], a, b, model(w, modes[mi], a, b), (b == 64'd0),
                 $sformatf("rand_w%0d_%s_%0d", w, (modes[mi] == CMD_DIV) ? "div" : "divu", k));
        end
      end
    end
  endtask

  initial begin
    drive(32, CMD_NOP, 64'd0, 64'd0);
    drive(16, CMD_NOP, 64'd0, 64'd0);
    drive(8,  CMD_NOP, 64'd0, 64'd0);
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_reset_abort();
    test_ignored();
    test_width8_discard();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
